// File: rtl/spi_display_capture.sv
// rtl/spi_display_capture.sv - SPI mode-0 slave that captures 32-bit frames into an 8-digit display register
//
// Purpose: receives 32-bit frames MSB first from an external SPI master and
// commits only complete frames to the display register. The displayed frame
// is echoed on miso during the next transfer.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          synchronous reset, active-high
//   sclk         SPI serial clock (asynchronous, idles low)
//   cs_n         SPI chip select, active-low (asynchronous)
//   mosi         SPI data in, MSB first (asynchronous)
//   miso         SPI data out, MSB first; 0 while no transfer is active
//   A..H         display register nibbles, A = bits [31:28] ... H = bits [3:0]
//   frame_valid  one-clk pulse when a 32-bit frame is committed
//   frame_err    one-clk pulse when a frame of any other length is rejected

module spi_display_capture #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [3:0] E,
  output logic [3:0] F,
  output logic [3:0] G,
  output logic [3:0] H,
  output logic       frame_valid,
  output logic       frame_err
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  // Fills with ones after reset; once full, the last sync stage reflects the
  // real pin rather than the reset idle level.
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_cs_armed;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic [31:0] r_shift;
  logic [31:0] r_miso_sh;
  logic [31:0] r_display;
  logic [5:0]  r_bit_cnt;
  logic        r_frame_valid;
  logic        r_frame_err;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_start;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_warm      <= '0;
      r_cs_armed  <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      // A chip select held low through reset must be seen high before any
      // frame may start.
      if (r_warm[SYNC_STAGES-1] && w_cs_s) begin
        r_cs_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall && r_cs_armed) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift       <= '0;
      r_miso_sh     <= '0;
      r_display     <= RESET_VALUE;
      r_bit_cnt     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_miso_sh <= r_display;
      end else if (r_state == ST_SHIFT) begin
        // Frame end takes priority; an sclk edge in the same cycle is dropped.
        if (w_cs_rise) begin
          if (r_bit_cnt == 6'd32) begin
            r_display     <= r_shift;
            r_frame_valid <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
        end else if (w_sclk_rise) begin
          r_shift <= {r_shift[30:0], w_mosi_s};
          if (r_bit_cnt != 6'd33) begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end
        end else if (w_sclk_fall) begin
          r_miso_sh <= {r_miso_sh[30:0], 1'b0};
        end
      end
    end
  end

  assign miso        = (r_state == ST_SHIFT) ? r_miso_sh[31] : 1'b0;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign A = r_display[31:28];
  assign B = r_display[27:24];
  assign C = r_display[23:20];
  assign D = r_display[19:16];
  assign E = r_display[15:12];
  assign F = r_display[11:8];
  assign G = r_display[7:4];
  assign H = r_display[3:0];

endmodule

// File: tb/tb_spi_display_capture.sv
// tb/tb_spi_display_capture.sv - directed self-checking bench for spi_display_capture

module tb_spi_display_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [3:0] A, B, C, D, E, F, G, H;
  logic       frame_valid;
  logic       frame_err;

  int n_vec  = 0;
  int n_fail = 0;
  int cnt_valid = 0;
  int cnt_err   = 0;

  spi_display_capture #(
    .SYNC_STAGES(2),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) cnt_valid++;
    if (frame_err)   cnt_err++;
  end

  function automatic logic [31:0] disp();
    return {A, B, C, D, E, F, G, H};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks nbits of data out MSB first (bit nbits-1 first) with cs_n already low;
  // miso is sampled just before each sclk rise.
  task automatic shift_bits(input logic [63:0] data, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mosi = data[nbits-1-i];
      wait_clk(4);
      rx = {rx[30:0], miso};
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
      wait_clk(4);
    end
  endtask

  task automatic send_frame(input logic [63:0] data, input int nbits, output logic [31:0] rx);
    @(negedge clk);
    cs_n = 1'b0;
    wait_clk(6);
    shift_bits(data, nbits, rx);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(3);
    n_vec++;
    if (disp() !== 32'h0000_0000) begin
      n_fail++; $display("FAIL reset_display: got %h want %h", disp(), 32'h0);
    end
    n_vec++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_vec++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    n_vec++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", frame_err); end
    rst = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_frame();
    logic [31:0] rx;
    int v0, e0;
    logic fv_seq [4];
    v0 = cnt_valid; e0 = cnt_err;
    @(negedge clk);
    cs_n = 1'b0;
    wait_clk(6);
    shift_bits(64'h1234_ABCD, 32, rx);
    cs_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fv_seq[k] = frame_valid;
      if (k == 2) begin
        n_vec++;
        if (disp() !== 32'h1234_ABCD) begin
          n_fail++; $display("FAIL frame_display_at_commit: got %h want 1234abcd", disp());
        end
      end
    end
    n_vec++;
    if ({fv_seq[0], fv_seq[1], fv_seq[2], fv_seq[3]} !== 4'b0010) begin
      n_fail++;
      $display("FAIL frame_valid_timing: got %b%b%b%b want 0010", fv_seq[0], fv_seq[1], fv_seq[2], fv_seq[3]);
    end
    wait_clk(4);
    n_vec++;
    if ({A, B, C, D, E, F, G, H} !== {4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD}) begin
      n_fail++; $display("FAIL frame_digits: got %h want 1234abcd", disp());
    end
    n_vec++;
    if (cnt_valid - v0 !== 1) begin
      n_fail++; $display("FAIL frame_valid_count: got %0d want 1", cnt_valid - v0);
    end
    n_vec++;
    if (cnt_err - e0 !== 0) begin
      n_fail++; $display("FAIL frame_err_count: got %0d want 0", cnt_err - e0);
    end
  endtask

  task automatic test_bad_length();
    logic [31:0] rx;
    int v0, e0;
    v0 = cnt_valid; e0 = cnt_err;
    send_frame(64'h0000_0000_5555_5555, 31, rx);
    n_vec++;
    if (cnt_err - e0 !== 1) begin
      n_fail++; $display("FAIL short_err_count: got %0d want 1", cnt_err - e0);
    end
    send_frame(64'h0000_0001_AAAA_AAAA, 33, rx);
    n_vec++;
    if (cnt_err - e0 !== 2) begin
      n_fail++; $display("FAIL long_err_count: got %0d want 2", cnt_err - e0);
    end
    n_vec++;
    if (cnt_valid - v0 !== 0) begin
      n_fail++; $display("FAIL bad_valid_count: got %0d want 0", cnt_valid - v0);
    end
    n_vec++;
    if (disp() !== 32'h1234_ABCD) begin
      n_fail++; $display("FAIL bad_display: got %h want 1234abcd", disp());
    end
  endtask

  task automatic test_echo();
    logic [31:0] rx;
    int v0;
    v0 = cnt_valid;
    send_frame(64'hFFFF_FFFF, 32, rx);
    n_vec++;
    if (rx !== 32'h1234_ABCD) begin
      n_fail++; $display("FAIL echo_miso: got %h want 1234abcd", rx);
    end
    n_vec++;
    if (disp() !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL echo_display: got %h want ffffffff", disp());
    end
    n_vec++;
    if (cnt_valid - v0 !== 1) begin
      n_fail++; $display("FAIL echo_valid_count: got %0d want 1", cnt_valid - v0);
    end
    n_vec++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL idle_miso: got %b want 0", miso); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx;
    int v0, e0;
    @(negedge clk);
    cs_n = 1'b0;
    wait_clk(6);
    shift_bits(64'hA5A5, 16, rx);
    v0 = cnt_valid; e0 = cnt_err;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    n_vec++;
    if (disp() !== 32'h0000_0000) begin
      n_fail++; $display("FAIL midreset_display: got %h want 00000000", disp());
    end
    shift_bits(64'h5A5A, 16, rx);
    n_vec++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL midreset_miso: got %b want 0", miso); end
    cs_n = 1'b1;
    wait_clk(8);
    n_vec++;
    if (disp() !== 32'h0000_0000) begin
      n_fail++; $display("FAIL midreset_display_end: got %h want 00000000", disp());
    end
    n_vec++;
    if ((cnt_valid - v0 !== 0) || (cnt_err - e0 !== 0)) begin
      n_fail++;
      $display("FAIL midreset_pulses: got valid %0d err %0d want 0 0", cnt_valid - v0, cnt_err - e0);
    end
    v0 = cnt_valid;
    send_frame(64'h0000_0007, 32, rx);
    n_vec++;
    if (H !== 4'h7 || disp() !== 32'h0000_0007) begin
      n_fail++; $display("FAIL after_reset_frame: got %h want 00000007", disp());
    end
    n_vec++;
    if (cnt_valid - v0 !== 1) begin
      n_fail++; $display("FAIL after_reset_valid_count: got %0d want 1", cnt_valid - v0);
    end
  endtask

  task automatic test_zero_length();
    int v0, e0;
    v0 = cnt_valid; e0 = cnt_err;
    @(negedge clk);
    cs_n = 1'b0;
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(8);
    n_vec++;
    if (cnt_err - e0 !== 1) begin
      n_fail++; $display("FAIL zero_err_count: got %0d want 1", cnt_err - e0);
    end
    n_vec++;
    if (cnt_valid - v0 !== 0) begin
      n_fail++; $display("FAIL zero_valid_count: got %0d want 0", cnt_valid - v0);
    end
    n_vec++;
    if (disp() !== 32'h0000_0007) begin
      n_fail++; $display("FAIL zero_display: got %h want 00000007", disp());
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bad_length();
    test_echo();
    test_reset_mid_frame();
    test_zero_length();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_display_capture.md
Name: spi_display_capture

Overview:
SPI mode-0 slave receiver that feeds the eight-digit seven-segment driver. It captures 32-bit frames from an external master and holds the last valid frame as eight 4-bit digit values A..H. Bad frames are rejected so the display never shows partial data. On MISO it echoes back the frame currently being displayed.

Parameters:
SYNC_STAGES, 2, flop depth of the input synchronizer for sclk, cs_n and mosi (minimum 2).
RESET_VALUE, 32'h0000_0000, display register contents after reset.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous reset, active-high.
sclk  input  1  SPI serial clock, asynchronous to clk, idles low.
cs_n  input  1  SPI chip select, active-low, asynchronous.
mosi  input  1  SPI data in, MSB first, asynchronous.
miso  output  1  SPI data out, MSB first.
A  output  4  display register bits [31:28].
B  output  4  display register bits [27:24].
C  output  4  display register bits [23:20].
D  output  4  display register bits [19:16].
E  output  4  display register bits [15:12].
F  output  4  display register bits [11:8].
G  output  4  display register bits [7:4].
H  output  4  display register bits [3:0].
frame_valid  output  1  one-clk pulse when a frame is committed.
frame_err  output  1  one-clk pulse when a frame is rejected.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst, named clk/rst.
- Synchronizers: sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - On reset, the sync flops load idle levels: sclk=0, cs_n=1, mosi=0.
  - Edge detect compares the last sync stage with a one-flop delayed copy.
- Clock ratio: clk must be at least 8x sclk. Faster sclk is out of scope and behaviour is undefined.
- FSM states IDLE and SHIFT.
  - IDLE -> SHIFT on a synchronized cs_n falling edge. Action: bit_cnt=0, shift_reg=0, MISO shifter loaded from the display register.
  - SHIFT -> IDLE on a synchronized cs_n rising edge.
  - A cs_n that is already low when reset releases is ignored. No frame starts until cs_n goes high then low again.
- In SHIFT:
  - sclk rising edge: shift_reg <= {shift_reg[30:0], mosi_sync}. bit_cnt increments, saturating at 33 (6-bit counter).
  - sclk falling edge: MISO shifter shifts left by 1 and fills with 0.
- miso = MISO shifter bit [31] while in SHIFT, 0 in IDLE.
  - The first bit (display[31]) is valid at most SYNC_STAGES+1 clk after cs_n falls.
- Frame end (cs_n rising edge while in SHIFT):
  - bit_cnt==32: display register <= shift_reg and frame_valid pulses for exactly 1 clk. The new A..H appear in that same cycle, SYNC_STAGES+1 clk after the pin edge.
  - bit_cnt!=32 (0..31 or saturated 33): display register unchanged and frame_err pulses for 1 clk.
- Priority: if an sclk edge and a cs_n rising edge are detected in the same clk, the cs_n edge wins and the sclk edge is discarded.
- sclk edges in IDLE are ignored.
- Reset values: display register = RESET_VALUE, so A..H = RESET_VALUE nibbles. miso=0, frame_valid=0, frame_err=0, FSM=IDLE, bit_cnt=0.
- Reset mid-frame: the partial frame is discarded, no frame_err pulse, and the display returns to RESET_VALUE.
- A..H are registered and stable between commits. The display register is never partially updated.

Test Plan:
- Reset: assert rst for 3 clk -> A..H=0, miso=0, frame_valid=0, frame_err=0.
- Frame 0x1234ABCD, 32 bits -> A=1, B=2, C=3, D=4, E=A, F=B, G=C, H=D, with frame_valid high for exactly 1 clk, SYNC_STAGES+1 clk after cs_n rises.
- Short 31-bit frame, then a 33-bit frame, starting from a display of 0x1234ABCD:
  - Each frame gives one frame_err pulse.
  - A..H still show 0x1234ABCD.
  - frame_valid stays 0.
- Echo: with display 0x1234ABCD, send frame 0xFFFFFFFF -> the 32 bits sampled on miso equal 0x1234ABCD, and the display becomes 0xFFFFFFFF.
- Reset mid-frame after 16 bits, with cs_n still low and then completing 16 more bits:
  - Display = RESET_VALUE, no pulses.
  - The next full frame 0x00000007 commits (H=7).
- Zero-length frame (cs_n low then high with no sclk) -> one frame_err pulse, display unchanged.
